// File: rtl/dmem_resp.sv
// CPU data-port responder: word-wide data RAM plus an MMIO page holding a console
// TX FIFO, a 64-bit cycle counter with a high-word shadow, and a tohost halt register.
module dmem_resp #(
  parameter int unsigned XLEN       = 32,
  parameter logic [63:0] RAM_BASE   = 64'h0000_0000,
  parameter int unsigned RAM_WORDS  = 1024,
  parameter logic [63:0] MMIO_BASE  = 64'h1000_0000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            mem_load,
  input  logic            mem_store,
  input  logic [XLEN-1:0] address,
  input  logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] load_data,
  output logic            con_valid,
  output logic [7:0]      con_data,
  input  logic            con_ready,
  output logic            halt,
  output logic [XLEN-1:0] exit_code
);

  localparam int unsigned BO = $clog2(XLEN / 8);
  localparam int unsigned AW = $clog2(RAM_WORDS);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [XLEN-1:0] RAM_LO    = RAM_BASE[XLEN-1:0];
  localparam logic [XLEN-1:0] RAM_BYTES = XLEN'(RAM_WORDS * (XLEN / 8));
  localparam logic [XLEN-1:0] MMIO_LO   = MMIO_BASE[XLEN-1:0];

  typedef enum logic [3:0] {
    REG_TX     = 4'h0,
    REG_STATUS = 4'h1,
    REG_CYC_LO = 4'h2,
    REG_CYC_HI = 4'h3,
    REG_TOHOST = 4'h4
  } mmio_reg_e;

  logic [XLEN-1:0] ram_q [RAM_WORDS];
  logic [7:0]      fifo_q [FIFO_DEPTH];

  logic [63:0]     cyc_q, cyc_d;
  logic [31:0]     shadow_q, shadow_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d, err_q, err_d, halt_q, halt_d;
  logic [XLEN-1:0] exit_code_q, exit_code_d;

  logic [XLEN-1:0] ram_off;
  logic [AW-1:0]   ram_idx;
  logic            ram_hit, mmio_hit, ram_we;
  logic            is_load, full, pop, tx_push, push_ok, status_wr;
  logic [15:0]     status;

  // Unsigned subtraction folds the below-base case into the single upper-bound test.
  assign ram_off  = address - RAM_LO;
  assign ram_hit  = ram_off < RAM_BYTES;
  assign ram_idx  = ram_off[BO+AW-1:BO];
  assign mmio_hit = address[XLEN-1:6] == MMIO_LO[XLEN-1:6];

  assign is_load   = mem_load & ~mem_store;
  assign full      = count_q == CW'(FIFO_DEPTH);
  assign con_valid = count_q != '0;
  assign con_data  = con_valid ? fifo_q[rd_ptr_q] : '0;
  assign pop       = con_valid & con_ready;
  assign status    = {8'(count_q), 4'b0, err_q, ovf_q, ~con_valid, full};

  assign halt      = halt_q;
  assign exit_code = exit_code_q;

  always_comb begin
    load_data = '0;
    if (ram_hit) begin
      load_data = ram_q[ram_idx];
    end else if (mmio_hit) begin
      case (address[5:2])
        REG_STATUS: load_data = XLEN'(status);
        REG_CYC_LO: load_data = cyc_q[XLEN-1:0];
        REG_CYC_HI: load_data = XLEN'(shadow_q);
        REG_TOHOST: load_data = exit_code_q;
        default:    load_data = '0;
      endcase
    end
  end

  always_comb begin
    ram_we    = mem_store & ram_hit;
    tx_push   = mem_store & mmio_hit & (address[5:2] == REG_TX);
    status_wr = mem_store & mmio_hit & (address[5:2] == REG_STATUS);
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    push_ok   = tx_push & (~full | pop);

    cyc_d    = cyc_q + 64'd1;
    shadow_d = shadow_q;
    if (is_load && mmio_hit && (address[5:2] == REG_CYC_LO)) begin
      shadow_d = cyc_q[63:32];
    end

    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    ovf_d = ovf_q | (tx_push & full & ~pop);
    err_d = err_q | ((mem_load | mem_store) & ~ram_hit & ~mmio_hit);
    if (status_wr) begin
      ovf_d = 1'b0;
      err_d = 1'b0;
    end

    halt_d      = halt_q;
    exit_code_d = exit_code_q;
    if (mem_store && mmio_hit && (address[5:2] == REG_TOHOST) && !halt_q &&
        (store_data != '0)) begin
      halt_d      = 1'b1;
      exit_code_d = store_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cyc_q       <= '0;
      shadow_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      halt_q      <= 1'b0;
      exit_code_q <= '0;
    end else begin
      cyc_q       <= cyc_d;
      shadow_q    <= shadow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      halt_q      <= halt_d;
      exit_code_q <= exit_code_d;
    end
  end

  // Storage arrays carry no reset; con_data is masked while the FIFO is empty.
  always_ff @(posedge clock) begin
    if (ram_we) begin
      ram_q[ram_idx] <= store_data;
    end
    if (push_ok) begin
      fifo_q[wr_ptr_q] <= store_data[7:0];
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: RAM, console FIFO, cycle counter/shadow, tohost and reset.
module tb_dmem_resp;

  localparam logic [31:0] A_TX     = 32'h1000_0000;
  localparam logic [31:0] A_STATUS = 32'h1000_0004;
  localparam logic [31:0] A_CYC_LO = 32'h1000_0008;
  localparam logic [31:0] A_CYC_HI = 32'h1000_000C;
  localparam logic [31:0] A_TOHOST = 32'h1000_0010;

  logic        clock, reset, mem_load, mem_store, con_ready, con_valid, halt;
  logic [31:0] address, store_data, load_data, exit_code;
  logic [7:0]  con_data;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_resp #(
    .XLEN(32),
    .RAM_BASE(64'h0000_0000),
    .RAM_WORDS(1024),
    .MMIO_BASE(64'h1000_0000),
    .FIFO_DEPTH(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .mem_load(mem_load),
    .mem_store(mem_store),
    .address(address),
    .store_data(store_data),
    .load_data(load_data),
    .con_valid(con_valid),
    .con_data(con_data),
    .con_ready(con_ready),
    .halt(halt),
    .exit_code(exit_code)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_bus(input logic ld, input logic st, input logic [31:0] a,
                         input logic [31:0] d);
    mem_load   = ld;
    mem_store  = st;
    address    = a;
    store_data = d;
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    set_bus(1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    con_ready = 1'b0;
    set_bus(1'b0, 1'b0, A_STATUS, 32'h0);

    // Reset state
    @(negedge clock);
    #1;
    check_eq("rst_status", load_data, 64'h0002);
    check_eq("rst_con_valid", con_valid, 0);
    check_eq("rst_con_data", con_data, 0);
    check_eq("rst_halt", halt, 0);
    check_eq("rst_exit_code", exit_code, 0);
    address = A_CYC_LO;
    #1;
    check_eq("rst_cyc_lo", load_data, 0);
    @(negedge clock);
    reset = 1'b0;

    // RAM write/read and same-cycle old-word visibility
    set_bus(1'b0, 1'b1, 32'h40, 32'h1111_1111); step();
    set_bus(1'b0, 1'b1, 32'h44, 32'h2222_2222); step();
    set_bus(1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF); #1;
    check_eq("ram_same_cycle_old", load_data, 64'h1111_1111);
    step();
    set_bus(1'b1, 1'b0, 32'h40, 32'h0); #1;
    check_eq("ram_load_40", load_data, 64'hDEAD_BEEF);
    address = 32'h42; #1;
    check_eq("ram_low_bits_ignored", load_data, 64'hDEAD_BEEF);
    address = 32'h44; #1;
    check_eq("ram_load_44", load_data, 64'h2222_2222);
    set_bus(1'b0, 1'b1, 32'hFFC, 32'h1234_5678); step();
    set_bus(1'b1, 1'b0, 32'hFFC, 32'h0); #1;
    check_eq("ram_last_word", load_data, 64'h1234_5678);

    // First byte past RAM is unmapped
    set_bus(1'b1, 1'b0, 32'h1000, 32'h0); #1;
    check_eq("unmapped_past_ram", load_data, 0);
    step();
    set_bus(1'b1, 1'b0, A_STATUS, 32'h0); #1;
    check_eq("status_err_set", load_data, 64'h000A);
    set_bus(1'b0, 1'b1, A_STATUS, 32'h0); step();
    set_bus(1'b1, 1'b0, 32'h1000_0014, 32'h0); #1;
    check_eq("mmio_other_offset", load_data, 0);
    step();
    set_bus(1'b1, 1'b0, A_STATUS, 32'h0); #1;
    check_eq("status_err_cleared", load_data, 64'h0002);

    // Overfill with sink stalled, then drain in order
    con_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      set_bus(1'b0, 1'b1, A_TX, 32'(8'h41 + i)); step();
    end
    set_bus(1'b1, 1'b0, A_STATUS, 32'h0); #1;
    check_eq("fifo_full_ovf", load_data, 64'h0805);
    check_eq("fifo_head_stalled", con_data, 8'h41);
    set_bus(1'b0, 1'b0, 32'h0, 32'h0);
    con_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check_eq("drain_valid", con_valid, 1);
      check_eq("drain_data", con_data, 64'(8'h41 + i));
      step();
    end
    #1;
    check_eq("drain_empty", con_valid, 0);
    set_bus(1'b1, 1'b0, A_STATUS, 32'h0); #1;
    check_eq("status_ovf_sticky", load_data, 64'h0006);
    set_bus(1'b0, 1'b1, A_STATUS, 32'h0); step();

    // Push into a full FIFO while it pops
    con_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_bus(1'b0, 1'b1, A_TX, 32'(8'h61 + i)); step();
    end
    set_bus(1'b1, 1'b0, A_STATUS, 32'h0); #1;
    check_eq("fifo2_full", load_data, 64'h0801);
    set_bus(1'b0, 1'b1, A_TX, 32'h5A);
    con_ready = 1'b1; #1;
    check_eq("fifo2_head_a", con_data, 8'h61);
    step();
    set_bus(1'b1, 1'b0, A_STATUS, 32'h0); #1;
    check_eq("fifo2_count_kept", load_data, 64'h0801);
    for (int i = 0; i < 8; i++) begin
      #1;
      check_eq("fifo2_drain", con_data, (i < 7) ? 64'(8'h62 + i) : 64'h5A);
      step();
    end
    #1;
    check_eq("fifo2_empty", con_valid, 0);
    con_ready = 1'b0;

    // Cycle counter and shadow
    do_reset();
    repeat (100) @(posedge clock);
    @(negedge clock);
    set_bus(1'b1, 1'b0, A_CYC_LO, 32'h0); #1;
    check_eq("cyc_lo_100", load_data, 100);
    step();
    set_bus(1'b1, 1'b0, A_CYC_HI, 32'h0); #1;
    check_eq("cyc_hi_0", load_data, 0);

    set_bus(1'b0, 1'b0, A_CYC_LO, 32'h0);
    force dut.cyc_q = 64'h0000_0000_FFFF_FFFF;
    #1;
    check_eq("cyc_lo_ffff", load_data, 64'hFFFF_FFFF);
    mem_load = 1'b1;
    step();
    release dut.cyc_q;
    set_bus(1'b1, 1'b0, A_CYC_HI, 32'h0); #1;
    check_eq("cyc_hi_after_ffff", load_data, 0);

    set_bus(1'b1, 1'b0, A_CYC_LO, 32'h0);
    force dut.cyc_q = 64'h0000_0005_0000_0007;
    #1;
    check_eq("cyc_lo_forced", load_data, 7);
    step();
    release dut.cyc_q;
    set_bus(1'b1, 1'b0, A_CYC_HI, 32'h0); #1;
    check_eq("cyc_hi_shadow", load_data, 5);

    // tohost, unmapped access, reset mid-transfer
    do_reset();
    set_bus(1'b0, 1'b1, A_TOHOST, 32'h0); step();
    #1;
    check_eq("tohost_zero_no_halt", halt, 0);
    set_bus(1'b0, 1'b1, A_TOHOST, 32'h3); step();
    #1;
    check_eq("tohost_halt", halt, 1);
    check_eq("tohost_exit3", exit_code, 3);
    set_bus(1'b0, 1'b1, A_TOHOST, 32'h5); step();
    #1;
    check_eq("tohost_ignored", exit_code, 3);
    set_bus(1'b1, 1'b0, A_TOHOST, 32'h0); #1;
    check_eq("tohost_read", load_data, 3);
    address = A_CYC_LO; #1;
    check_eq("cyc_runs_after_halt", load_data, 3);
    step();
    set_bus(1'b1, 1'b0, 32'h2000_0000, 32'h0); #1;
    check_eq("unmapped_load_zero", load_data, 0);
    step();
    set_bus(1'b1, 1'b0, A_STATUS, 32'h0); #1;
    check_eq("unmapped_err", load_data, 64'h000A);
    set_bus(1'b0, 1'b1, A_TX, 32'h51); step();
    set_bus(1'b0, 1'b0, A_STATUS, 32'h0); #1;
    check_eq("post_halt_push", con_data, 8'h51);
    #2;
    reset = 1'b1;
    #1;
    check_eq("async_rst_valid", con_valid, 0);
    check_eq("async_rst_data", con_data, 0);
    check_eq("async_rst_halt", halt, 0);
    check_eq("async_rst_exit", exit_code, 0);
    check_eq("async_rst_status", load_data, 64'h0002);
    address = 32'h40; #1;
    check_eq("ram_survives_reset", load_data, 64'hDEAD_BEEF);
    @(negedge clock);
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
